// File: rtl/quot_reconstruct_pkg.sv
// ---------------------------------------------------------------------------
// qrecon_pkg
// Shared types and encodings for the quotient / square-root reconstruction
// checker.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qrecon_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Operation encodings. Any nonzero op selects the square-root check.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;

  // Unsigned absolute difference between two operands of equal width.
  function automatic logic [63:0] abs_diff64(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

`default_nettype wire

// File: rtl/quot_reconstruct_if.sv
// ---------------------------------------------------------------------------
// quot_reconstruct_if
// Request / result handshake bundle for quot_reconstruct.
// master = requester/consumer side, slave = checker side.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface quot_reconstruct_if #(
  parameter int WIDTH = 30
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] numerator;
  logic [WIDTH-1:0] denominator;
  logic [WIDTH-1:0] quotient;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] remainder;
  logic             rem_sign;
  logic             exact;
  logic             ovf;

  modport master (
    output in_valid, op, numerator, denominator, quotient, out_ready,
    input  in_ready, out_valid, remainder, rem_sign, exact, ovf
  );

  modport slave (
    input  in_valid, op, numerator, denominator, quotient, out_ready,
    output in_ready, out_valid, remainder, rem_sign, exact, ovf
  );
endinterface

`default_nettype wire

// File: rtl/quot_reconstruct_mac.sv
// ---------------------------------------------------------------------------
// qrecon_mac
// Serial shift-add multiplier: one multiplier bit per step, LSB first.
// Exposes the upper WIDTH+2 product bits (integer overflow bits plus the
// truncated Q2 reconstruction).
// Optional macro: QRECON_EARLY_EXIT_EN -- 'last' also fires once the
// remaining multiplier bits are all zero.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qrecon_mac #(
  parameter int WIDTH = 30
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               start,
  input  wire logic               step,
  input  wire logic [WIDTH-1:0]   multiplicand,
  input  wire logic [WIDTH-1:0]   multiplier,
  output logic [WIDTH+1:0]        prod_hi,
  output logic                    last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign prod_hi = acc[2*WIDTH-1:WIDTH-2];

  // The step currently being taken is the final one.
`ifdef QRECON_EARLY_EXIT_EN
  assign last = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = (cnt == CW'(WIDTH - 1));
`endif

  // Load operands on start, then add the shifted multiplicand per set bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, multiplicand};
      mplier <= multiplier;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/quot_reconstruct.sv
// ---------------------------------------------------------------------------
// quot_reconstruct
// Checks a divide (Q*D vs N) or square-root (Q*Q vs N) result in unsigned
// Q2.(WIDTH-2) fixed point: reports |N-P|, sign, exactness and overflow.
// Optional macro: QRECON_EARLY_EXIT_EN -- data-dependent multiply latency.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module quot_reconstruct
  import qrecon_pkg::*;
#(
  parameter int WIDTH = 30
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  quot_reconstruct_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] remainder_q;
  logic             rem_sign_q;
  logic             exact_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             mac_start;
  logic             mac_step;
  logic             mac_last;
  logic [WIDTH-1:0] mac_multiplier;
  logic [WIDTH+1:0] prod_hi;
  logic [WIDTH-1:0] p_val;
  logic             p_ovf;

  assign mac_start      = (state == S_IDLE) && bus.in_valid;
  assign mac_step       = (state == S_MUL);
  assign mac_multiplier = (bus.op == OP_DIV) ? bus.denominator : bus.quotient;

  qrecon_mac #(.WIDTH(WIDTH)) u_mac (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mac_start),
    .step         (mac_step),
    .multiplicand (bus.quotient),
    .multiplier   (mac_multiplier),
    .prod_hi      (prod_hi),
    .last         (mac_last)
  );

  // Truncated reconstruction and integer overflow of the full product.
  assign p_val = prod_hi[WIDTH-1:0];
  assign p_ovf = |prod_hi[WIDTH+1:WIDTH];

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.remainder = remainder_q;
  assign bus.rem_sign  = rem_sign_q;
  assign bus.exact     = exact_q;
  assign bus.ovf       = ovf_q;

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      num_q       <= '0;
      remainder_q <= '0;
      rem_sign_q  <= 1'b0;
      exact_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            num_q <= bus.numerator;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          if (mac_last) begin
            state <= S_SUB;
          end
        end
        S_SUB: begin
          remainder_q <= (p_val > num_q) ? (p_val - num_q) : (num_q - p_val);
          rem_sign_q  <= (p_val > num_q);
          exact_q     <= (p_val == num_q);
          ovf_q       <= p_ovf;
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quot_reconstruct.sv
// ---------------------------------------------------------------------------
// tb_quot_reconstruct
// Directed self-checking bench for quot_reconstruct (WIDTH = 30).
// Optional macro: QRECON_EARLY_EXIT_EN -- adjusts expected latencies.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_quot_reconstruct;

  localparam int W = 30;
`ifdef QRECON_EARLY_EXIT_EN
  localparam int LAT_D10 = 30;   // D = 1.0: top set bit is bit 28
  localparam int LAT_D1  = 2;
`else
  localparam int LAT_D10 = 31;
  localparam int LAT_D1  = 31;
`endif

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  quot_reconstruct_if #(.WIDTH(W)) bus ();

  quot_reconstruct #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for its accept edge, then count edges to out_valid.
  task automatic send(input logic [W-1:0] n, input logic [W-1:0] d,
                      input logic [W-1:0] q, input logic [1:0] o, output int lat);
    bus.numerator   = n;
    bus.denominator = d;
    bus.quotient    = q;
    bus.op          = o;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("drain_in_ready",  {63'd0, bus.in_ready},  64'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_rem;
    n_cmp = 0;
    n_err = 0;
    reset_n         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.op          = 2'b00;
    bus.numerator   = '0;
    bus.denominator = '0;
    bus.quotient    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_remainder", {34'd0, bus.remainder}, 64'd0);
    chk("rst_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Divide exact: 0.75 / 1.0 = 0.75
    send(30'h0C000000, 30'h10000000, 30'h0C000000, 2'b00, lat);
    chk("div_exact_latency", 64'(lat), 64'(LAT_D10));
    chk("div_exact_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b010);
    chk("div_exact_rem", {34'd0, bus.remainder}, 64'd0);
    drain();

    // Divide over by one LSB
    send(30'h0C000000, 30'h10000000, 30'h0C000001, 2'b00, lat);
    chk("div_over_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b100);
    chk("div_over_rem", {34'd0, bus.remainder}, 64'd1);
    drain();

    // Divide under: P = 0.5, N = 0.75
    send(30'h0C000000, 30'h10000000, 30'h08000000, 2'b00, lat);
    chk("div_under_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b000);
    chk("div_under_rem", {34'd0, bus.remainder}, 64'h04000000);
    drain();

    // Sqrt: 1.0 * 1.0 = 1.0, denominator irrelevant
    send(30'h10000000, 30'h3FFFFFFF, 30'h10000000, 2'b01, lat);
    chk("sqrt_latency", 64'(lat), 64'(LAT_D10));
    chk("sqrt_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b010);
    chk("sqrt_rem", {34'd0, bus.remainder}, 64'd0);
    drain();

    // Sqrt with op=11: 1.5 * 1.5 = 2.25 (0x24000000) vs N = 2.0
    send(30'h20000000, 30'h00000001, 30'h18000000, 2'b11, lat);
    chk("sqrt11_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b100);
    chk("sqrt11_rem", {34'd0, bus.remainder}, 64'h04000000);
    drain();

    // Overflow: 3.0 * 2.0 = 6.0, truncated P = 2.0
    send(30'h00000000, 30'h20000000, 30'h30000000, 2'b00, lat);
    chk("ovf_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b101);
    chk("ovf_rem", {34'd0, bus.remainder}, 64'h20000000);

    // Backpressure: hold in DONE, new request attempts must be ignored
    held_rem = bus.remainder;
    bus.numerator   = 30'h12345678;
    bus.quotient    = 30'h01234567;
    bus.denominator = 30'h00000003;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
      chk("bp_rem", {34'd0, bus.remainder}, {34'd0, held_rem});
      chk("bp_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b101);
    end
    bus.in_valid = 1'b0;
    drain();

    // Small multiplier: P truncates to 0, remainder = N
    send(30'h05000000, 30'h00000001, 30'h0C000000, 2'b00, lat);
    chk("small_latency", 64'(lat), 64'(LAT_D1));
    chk("small_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b000);
    chk("small_rem", {34'd0, bus.remainder}, 64'h05000000);
    drain();

    // Reset mid-MUL: 10 cycles into the multiply
    bus.numerator   = 30'h0C000000;
    bus.denominator = 30'h10000000;
    bus.quotient    = 30'h0C000001;
    bus.op          = 2'b00;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    chk("mul_in_ready", {63'd0, bus.in_ready}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_rem", {34'd0, bus.remainder}, 64'd0);
    chk("midrst_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'd0);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", {63'd0, bus.in_ready}, 64'd1);

    // Request after reset completes correctly
    send(30'h0C000000, 30'h10000000, 30'h0C000000, 2'b00, lat);
    chk("postrst_latency", 64'(lat), 64'(LAT_D10));
    chk("postrst_flags", {61'd0, bus.rem_sign, bus.exact, bus.ovf}, 64'b010);
    chk("postrst_rem", {34'd0, bus.remainder}, 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quot_reconstruct.md
QUOT_RECONSTRUCT -- requirements
Module: quot_reconstruct

Interface
REQ-001 SHALL have parameter WIDTH, default 30, operand width; fixed-point unsigned Q2.(WIDTH-2): 2 integer bits, WIDTH-2 fraction bits.
REQ-002 SHALL have clk  input  1  sole clock, rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have in_valid  input  1  request valid.
REQ-005 SHALL have in_ready  output  1  block can accept a request.
REQ-006 SHALL have op  input  2  00 = divide check (Q*D vs N); any nonzero = sqrt check (Q*Q vs N).
REQ-007 SHALL have numerator, denominator, quotient  input  WIDTH each  operands; denominator ignored when op != 00.
REQ-008 SHALL have out_valid  output  1  result valid.
REQ-009 SHALL have out_ready  input  1  consumer accepts result.
REQ-010 SHALL have remainder  output  WIDTH  |N - P|, where P = truncated reconstruction.
REQ-011 SHALL have rem_sign  output  1  1 when P > N.
REQ-012 SHALL have exact  output  1  1 when P == N.
REQ-013 SHALL have ovf  output  1  1 when the full product is >= 4.0.

Function
REQ-014 SHALL implement states IDLE, MUL, SUB, DONE; in_ready = (state == IDLE).
REQ-015 SHALL accept a request on the rising edge with in_valid && in_ready: latch N, op, multiplicand = quotient, multiplier = (op==00 ? denominator : quotient); clear the 2*WIDTH accumulator and bit counter; go to MUL.
REQ-016 SHALL, in MUL, process one multiplier bit per cycle, LSB first: if the bit is 1, add the multiplicand shifted left by the bit index to the accumulator; after exactly WIDTH MUL cycles go to SUB.
REQ-017 SHALL, in SUB (one cycle), form P = acc[2*WIDTH-3:WIDTH-2]; ovf = |acc[2*WIDTH-1:2*WIDTH-2]; register remainder, rem_sign, exact; go to DONE.
REQ-018 SHALL assert out_valid only in DONE; the first out_valid cycle follows the accept edge by WIDTH+1 edges (31 at default).
REQ-019 SHALL hold all outputs stable in DONE until out_ready is 1; on that edge go to IDLE. No new request is accepted in the same cycle.
REQ-020 SHALL ignore in_valid and operand changes outside IDLE.
REQ-021 SHALL use unsigned arithmetic throughout; remainder equals N-P or P-N with no wrap.

Reset
REQ-022 SHALL, on reset_n low at any time (including mid-MUL or in DONE), go immediately to IDLE and clear the accumulator, counter, remainder, rem_sign, exact, ovf and out_valid to 0; in_ready = 1 while reset_n is low.

Configuration
REQ-023 SHALL support macro QRECON_EARLY_EXIT_EN. When defined, MUL goes to SUB as soon as the unprocessed multiplier bits are all zero, giving latency 2..WIDTH+1. When undefined, latency is fixed at WIDTH+1 and results are bit-identical.

Structure
REQ-024 SHALL place the state enum and op encodings (OP_DIV = 2'b00) in package qrecon_pkg.
REQ-025 SHALL put the shift-add step (accumulator, shifted multiplicand, counter) in sub-module qrecon_mac; quot_reconstruct holds the FSM, handshake and SUB logic.

Verification
REQ-026 Divide exact: N=0x0C000000, D=0x10000000, Q=0x0C000000, op=00 -> out_valid 31 cycles after accept; exact=1, rem_sign=0, remainder=0, ovf=0.
REQ-027 Divide over: N=0x0C000000, D=0x10000000, Q=0x0C000001 -> rem_sign=1, remainder=0x00000001, exact=0.
REQ-028 Sqrt: op=01, N=0x10000000, Q=0x10000000, D=0x3FFFFFFF -> exact=1, remainder=0; D has no effect.
REQ-029 Overflow: op=00, Q=0x30000000, D=0x20000000 -> ovf=1.
REQ-030 Backpressure/reset: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Pulse reset_n low at MUL cycle 10 -> IDLE next, all outputs 0, next request completes correctly.
REQ-031 With QRECON_EARLY_EXIT_EN: D=0x00000001 -> out_valid 2 cycles after accept, P=0, rem_sign=0, remainder=N.
